usb_tx_serializer: RTL and testbench

Parametrised transmit serializer for the hub's downstream/upstream bit path. It takes typed commands from the transaction layer and emits a gapless LSB-first bit stream: SYNC, PID, zero-fill fields, or pass-through words drawn from an internal staging buffer. USB bit stuffing is optional at elaboration time. It sits between the transaction receiver/FIFO and the NRZI encoder, and replaces the fixed two-register, 8-bit serializer with a depth-, width- and mode-configurable block that supports back-to-back commands and underrun detection.

---
 rtl/usb_pkg.sv | 29 ++
 rtl/usb_tx_serializer_if.sv | 29 ++
 rtl/usb_stage_fifo.sv | 45 ++++
 rtl/usb_tx_serializer.sv | 213 +++++++++++++++++++++
 tb/tb_usb_tx_serializer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// Shared encodings and constants for the USB transmit bit path.
package usb_pkg;

  typedef enum logic [2:0] {
    CMD_SYNC = 3'd0,
    CMD_PID  = 3'd1,
    CMD_ZERO = 3'd2,
    CMD_PASS = 3'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STUFF,
    ST_WAIT
  } tx_state_e;

  localparam logic [3:0] PID_ACK = 4'b0010;
  localparam logic [3:0] PID_NAK = 4'b1010;
  localparam logic [3:0] PID_IN  = 4'b1001;

  localparam int unsigned STUFF_THRESH = 6;

  // PID byte as sent on the wire: check nibble in the upper half.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_tx_serializer_if.sv
// Command, staging-data and serial-output signals of the transmit serializer.
interface usb_tx_serializer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_type;
  logic [3:0]            cmd_pid;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic                  bit_out;
  logic                  bit_val;
  logic                  bit_last;
  logic                  underrun;
  logic                  busy;

  modport master (
    output cmd_valid, cmd_type, cmd_pid, cmd_len, data_in, data_valid,
    input  cmd_ready, data_ready, bit_out, bit_val, bit_last, underrun, busy
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_pid, cmd_len, data_in, data_valid,
    output cmd_ready, data_ready, bit_out, bit_val, bit_last, underrun, busy
  );
endinterface

// File: rtl/usb_stage_fifo.sv
// Synchronous ring buffer staging pass-through words; show-ahead read port.
module usb_stage_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned STAGE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int unsigned AW = $clog2(STAGE_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] mem [STAGE_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/usb_tx_serializer.sv
// Command-driven LSB-first bit serializer with optional USB bit stuffing.
module usb_tx_serializer
  import usb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned STAGE_DEPTH = 2,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned SYNC_BITS   = 8,
  parameter int unsigned ZERO_BITS   = 16,
  parameter bit          STUFF_EN    = 1'b1
) (
  input logic clk,
  input logic rst,
  usb_tx_serializer_if.slave bus
);
  localparam int unsigned SH_W     = (DATA_WIDTH > 8) ? DATA_WIDTH : 8;
  localparam int unsigned MAX_A    = (SH_W > SYNC_BITS) ? SH_W : SYNC_BITS;
  localparam int unsigned MAX_BITS = (MAX_A > ZERO_BITS) ? MAX_A : ZERO_BITS;
  localparam int unsigned BC_W     = $clog2(MAX_BITS);
  localparam logic [BC_W-1:0] SYNC_LAST = BC_W'(SYNC_BITS - 1);
  localparam logic [BC_W-1:0] ZERO_LAST = BC_W'(ZERO_BITS - 1);
  localparam logic [BC_W-1:0] WORD_LAST = BC_W'(DATA_WIDTH - 1);

  tx_state_e             state, state_n;
  cmd_type_e             kind, kind_n;
  logic [SH_W-1:0]       shreg, shreg_n;
  logic [BC_W-1:0]       bits_left, bits_left_n;
  logic [LEN_WIDTH-1:0]  words_left, words_left_n;
  logic [2:0]            ones, ones_n, ones_base, ones_new;
  logic                  stuff_pend, stuff_pend_n;
  logic                  bit_q, val_q, last_q, underrun_q;
  logic                  bit_n, val_n, last_n, underrun_n;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd;
  logic                  final_cur, cmd_ready_c;
  logic                  start, advance, load_word, load_bit, stuff;
  logic [7:0]            pid_bits;

  usb_stage_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGE_DEPTH(STAGE_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (bus.data_valid),
    .wr_data(bus.data_in),
    .rd_en  (fifo_pop),
    .rd_data(fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Counters describe the bit on bit_out: no bits or words remain after it.
  assign final_cur   = (bits_left == '0) && (words_left == '0);
  assign cmd_ready_c = (state == ST_IDLE) || ((state == ST_SHIFT) && final_cur && !stuff_pend);

  assign bus.cmd_ready  = cmd_ready_c;
  assign bus.data_ready = !fifo_full;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.bit_out    = bit_q;
  assign bus.bit_val    = val_q;
  assign bus.bit_last   = last_q;
  assign bus.underrun   = underrun_q;

  always_comb begin
    state_n      = state;
    kind_n       = kind;
    shreg_n      = shreg;
    bits_left_n  = bits_left;
    words_left_n = words_left;
    ones_n       = '0;
    ones_base    = ones;
    ones_new     = '0;
    stuff_pend_n = 1'b0;
    stuff        = 1'b0;
    bit_n        = 1'b0;
    val_n        = 1'b0;
    last_n       = 1'b0;
    underrun_n   = 1'b0;
    fifo_pop     = 1'b0;
    start        = 1'b0;
    advance      = 1'b0;
    load_word    = 1'b0;
    load_bit     = 1'b0;
    pid_bits     = pid_byte(bus.cmd_pid);

    case (state)
      ST_IDLE:  start = bus.cmd_valid;
      ST_WAIT:  load_word = !fifo_empty;
      ST_SHIFT: begin
        if (stuff_pend) begin
          state_n = ST_STUFF;
          val_n   = 1'b1;
          last_n  = final_cur;
        end else if (final_cur) begin
          start   = bus.cmd_valid;
          state_n = ST_IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_STUFF: begin
        if (final_cur) state_n = ST_IDLE;
        else           advance = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    if (start) begin
      words_left_n = '0;
      case (bus.cmd_type)
        CMD_SYNC: begin
          kind_n      = CMD_SYNC;
          shreg_n     = '0;
          bits_left_n = SYNC_LAST;
          bit_n       = (SYNC_BITS == 1);
          ones_base   = '0;
          load_bit    = 1'b1;
        end
        CMD_PID: begin
          kind_n      = CMD_PID;
          shreg_n     = SH_W'(pid_bits[7:1]);
          bits_left_n = BC_W'(7);
          bit_n       = pid_bits[0];
          load_bit    = 1'b1;
        end
        CMD_ZERO: begin
          kind_n      = CMD_ZERO;
          shreg_n     = '0;
          bits_left_n = ZERO_LAST;
          load_bit    = 1'b1;
        end
        CMD_PASS: begin
          kind_n = CMD_PASS;
          if (bus.cmd_len != '0) begin
            words_left_n = bus.cmd_len - LEN_WIDTH'(1);
            if (fifo_empty) state_n   = ST_WAIT;
            else            load_word = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    // Word boundary mid-PASS: pull the next word, or abort if none is staged.
    if (advance) begin
      if (bits_left == '0) begin
        if (fifo_empty) begin
          underrun_n = 1'b1;
          state_n    = ST_IDLE;
        end else begin
          load_word    = 1'b1;
          words_left_n = words_left - LEN_WIDTH'(1);
        end
      end else begin
        bits_left_n = bits_left - BC_W'(1);
        shreg_n     = shreg >> 1;
        bit_n       = (kind == CMD_SYNC) ? (bits_left == BC_W'(1)) : shreg[0];
        load_bit    = 1'b1;
      end
    end

    if (load_word) begin
      fifo_pop    = 1'b1;
      shreg_n     = SH_W'(fifo_rd >> 1);
      bits_left_n = WORD_LAST;
      bit_n       = fifo_rd[0];
      load_bit    = 1'b1;
    end

    // Stuff decision is made as the bit is loaded so bit_last can skip it.
    if (load_bit) begin
      state_n      = ST_SHIFT;
      val_n        = 1'b1;
      ones_new     = bit_n ? (ones_base + 3'd1) : 3'd0;
      stuff        = STUFF_EN && (kind_n != CMD_SYNC) && (ones_new == 3'(STUFF_THRESH));
      ones_n       = STUFF_EN ? ones_new : 3'd0;
      stuff_pend_n = stuff;
      last_n       = (bits_left_n == '0) && (words_left_n == '0) && !stuff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      kind       <= CMD_SYNC;
      shreg      <= '0;
      bits_left  <= '0;
      words_left <= '0;
      ones       <= '0;
      stuff_pend <= 1'b0;
      bit_q      <= 1'b0;
      val_q      <= 1'b0;
      last_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_n;
      kind       <= kind_n;
      shreg      <= shreg_n;
      bits_left  <= bits_left_n;
      words_left <= words_left_n;
      ones       <= ones_n;
      stuff_pend <= stuff_pend_n;
      bit_q      <= bit_n;
      val_q      <= val_n;
      last_q     <= last_n;
      underrun_q <= underrun_n;
    end
  end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer with hand-computed bit streams.
module tb_usb_tx_serializer;
  import usb_pkg::*;

  logic        clk;
  logic        rst;
  int unsigned n_checks;
  int unsigned n_pass;
  int          acc_at;
  logic [15:0] seq;

  usb_tx_serializer_if #(.DATA_WIDTH(8), .LEN_WIDTH(8)) bus ();

  usb_tx_serializer #(
    .DATA_WIDTH (8),
    .STAGE_DEPTH(2),
    .LEN_WIDTH  (8),
    .SYNC_BITS  (8),
    .ZERO_BITS  (16),
    .STUFF_EN   (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] t, input logic [3:0] pid, input logic [7:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = t;
    bus.cmd_pid   = pid;
    bus.cmd_len   = len;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] d);
    bus.data_valid = 1'b1;
    bus.data_in    = d;
    tick();
    bus.data_valid = 1'b0;
  endtask

  // Expects n consecutive valid bits; bit_last only on the n-th.
  task automatic expect_bits(input string tag, input logic [31:0] exp, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]", tag, i),
            {29'd0, bus.bit_val, bus.bit_out, bus.bit_last},
            {29'd0, 1'b1, exp[i], (i == n - 1)});
      tick();
    end
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_val"},  {31'd0, bus.bit_val}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy},    32'd0);
  endtask

  task automatic expect_wait(input string tag);
    check({tag, "_val"},  {31'd0, bus.bit_val}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy},    32'd1);
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_type   = '0;
    bus.cmd_pid    = '0;
    bus.cmd_len    = '0;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    tick();
    tick();

    check("rst_bit_out",    {31'd0, bus.bit_out},    32'd0);
    check("rst_bit_val",    {31'd0, bus.bit_val},    32'd0);
    check("rst_bit_last",   {31'd0, bus.bit_last},   32'd0);
    check("rst_underrun",   {31'd0, bus.underrun},   32'd0);
    check("rst_busy",       {31'd0, bus.busy},       32'd0);
    check("rst_cmd_ready",  {31'd0, bus.cmd_ready},  32'd1);
    check("rst_data_ready", {31'd0, bus.data_ready}, 32'd1);
    rst = 1'b0;

    // SYNC then PID ACK offered early; ACK must be taken on SYNC's last bit.
    seq           = 16'hD280;
    acc_at        = -1;
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = CMD_SYNC;
    tick();
    bus.cmd_type  = CMD_PID;
    bus.cmd_pid   = PID_ACK;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("sync_ack[%0d]", i),
            {29'd0, bus.bit_val, bus.bit_out, bus.bit_last},
            {29'd0, 1'b1, seq[i], (i == 7 || i == 15)});
      if (bus.cmd_valid && bus.cmd_ready) acc_at = i;
      tick();
      if (acc_at == i) bus.cmd_valid = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    check("ack_accept_cycle", acc_at, 32'd7);
    expect_idle("after_sync_ack");

    // 0xFF with stuffing: six ones, inserted zero, two ones.
    write_word(8'hFF);
    send_cmd(CMD_PASS, 4'h0, 8'd1);
    expect_bits("stuff_ff", 32'h1BF, 9);
    expect_idle("after_stuff");

    // Underrun: one word staged for a three-word PASS.
    write_word(8'hA5);
    send_cmd(CMD_PASS, 4'h0, 8'd3);
    for (int unsigned i = 0; i < 8; i++) begin
      check($sformatf("underrun_bits[%0d]", i),
            {30'd0, bus.bit_val, bus.bit_last}, {30'd0, 1'b1, 1'b0});
      check($sformatf("underrun_data[%0d]", i), {31'd0, bus.bit_out}, {31'd0, seq_a5(i)});
      check($sformatf("underrun_early[%0d]", i), {31'd0, bus.underrun}, 32'd0);
      tick();
    end
    check("underrun_pulse", {31'd0, bus.underrun}, 32'd1);
    check("underrun_last",  {31'd0, bus.bit_last}, 32'd0);
    expect_idle("underrun_cycle");
    tick();
    check("underrun_clear", {31'd0, bus.underrun}, 32'd0);
    expect_idle("after_underrun");

    // PASS into an empty buffer waits; the word arrives 4 cycles later.
    send_cmd(CMD_PASS, 4'h0, 8'd1);
    for (int k = 1; k <= 4; k++) begin
      expect_wait($sformatf("wait_%0d", k));
      if (k == 4) begin
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h5A;
      end
      tick();
      bus.data_valid = 1'b0;
    end
    expect_wait("wait_after_write");
    tick();
    expect_bits("wait_5a", 32'h5A, 8);
    expect_idle("after_wait");

    send_cmd(CMD_PID, PID_NAK, 8'd0);
    expect_bits("pid_nak", 32'h5A, 8);
    send_cmd(CMD_PID, PID_IN, 8'd0);
    expect_bits("pid_in", 32'h69, 8);
    expect_idle("after_pid");

    send_cmd(3'd5, 4'h0, 8'd0);
    expect_idle("reserved");
    check("reserved_ready", {31'd0, bus.cmd_ready}, 32'd1);
    send_cmd(CMD_PASS, 4'h0, 8'd0);
    expect_idle("pass_len0");
    check("pass_len0_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // Fill, try writes while full (one alongside the pop), then drain.
    write_word(8'h11);
    write_word(8'h22);
    check("full_ready", {31'd0, bus.data_ready}, 32'd0);
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h33;
    tick();
    bus.data_valid = 1'b0;
    check("full_ready_hold", {31'd0, bus.data_ready}, 32'd0);
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h44;
    send_cmd(CMD_PASS, 4'h0, 8'd2);
    bus.data_valid = 1'b0;
    expect_bits("drain", 32'h2211, 16);
    check("drained_ready", {31'd0, bus.data_ready}, 32'd1);
    expect_idle("after_drain");
    send_cmd(CMD_PASS, 4'h0, 8'd1);
    expect_wait("empty_after_drain_a");
    tick();
    expect_wait("empty_after_drain_b");
    write_word(8'h00);
    expect_wait("flush_wait");
    tick();
    expect_bits("flush", 32'h0, 8);
    expect_idle("after_flush");

    // Reset on the 4th bit of ZERO with a word staged.
    write_word(8'h77);
    send_cmd(CMD_ZERO, 4'h0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("zero_bit[%0d]", i), {30'd0, bus.bit_val, bus.bit_out}, {30'd0, 1'b1, 1'b0});
      tick();
    end
    check("zero_bit4_val", {31'd0, bus.bit_val}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_val",        {31'd0, bus.bit_val},    32'd0);
    check("mid_rst_busy",       {31'd0, bus.busy},       32'd0);
    check("mid_rst_cmd_ready",  {31'd0, bus.cmd_ready},  32'd1);
    check("mid_rst_data_ready", {31'd0, bus.data_ready}, 32'd1);
    check("mid_rst_last",       {31'd0, bus.bit_last},   32'd0);
    rst = 1'b0;
    tick();
    expect_idle("post_rst");
    send_cmd(CMD_PASS, 4'h0, 8'd1);
    expect_wait("rst_empty_a");
    tick();
    expect_wait("rst_empty_b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  function automatic logic seq_a5(input int unsigned i);
    logic [7:0] v;
    v = 8'hA5;
    return v[i];
  endfunction

endmodule
